// File: rtl/seq_divider_param.sv
// seq_divider_param: multi-cycle restoring divider, 2N-bit dividend by N-bit divisor, signed/unsigned
module seq_divider_param #(
    parameter int N = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           sgn,
    input  logic [2*N-1:0] x,
    input  logic [N-1:0]   d,
    output logic           busy,
    output logic           done,
    output logic           divBy0,
    output logic           ov,
    output logic [N-1:0]   q,
    output logic [N-1:0]   w
);
    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] half = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] hmax = {1'b0, {(N-1){1'b1}}};
    typedef enum logic [2:0] {IDLE, CHECK, RUN, FIX, DONE} state_t;
    state_t state, state_nx;
    logic start_d, sgn_r, sx, sd, accept, ge, neg, fix_ov;
    logic [2*N-1:0] ax;
    logic [N-1:0] ad, pr, sr, hi, lo, trial;
    logic [N:0] rem;
    logic [CW-1:0] cnt;
    assign accept = start & ~start_d & (state == IDLE);
    assign hi = ax[2*N-1:N];
    assign lo = ax[N-1:0];
    // partial remainder is always below ad, so a passing trial fits in N bits
    assign rem = {pr, sr[N-1]};
    assign ge = rem >= {1'b0, ad};
    assign trial = rem[N-1:0] - ad;
    assign neg = sx ^ sd;
    assign fix_ov = sgn_r & (neg ? sr > half : sr > hmax);
    assign busy = state != IDLE;
    assign done = state == DONE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = accept ? CHECK : IDLE;
            CHECK: state_nx = (ad == '0 || hi >= ad) ? DONE : RUN;
            RUN:   state_nx = (cnt == CW'(1)) ? FIX : RUN;
            FIX:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_d <= 1'b0;
            sgn_r   <= 1'b0;
            sx      <= 1'b0;
            sd      <= 1'b0;
            ax      <= '0;
            ad      <= '0;
            pr      <= '0;
            sr      <= '0;
            cnt     <= '0;
            divBy0  <= 1'b0;
            ov      <= 1'b0;
            q       <= '0;
            w       <= '0;
        end else begin
            start_d <= start;
            case (state)
                IDLE: if (accept) begin
                    sgn_r  <= sgn;
                    sx     <= sgn & x[2*N-1];
                    sd     <= sgn & d[N-1];
                    ax     <= (sgn & x[2*N-1]) ? -x : x;
                    ad     <= (sgn & d[N-1]) ? -d : d;
                    divBy0 <= 1'b0;
                    ov     <= 1'b0;
                    q      <= '0;
                    w      <= '0;
                end
                CHECK: begin
                    if (ad == '0) divBy0 <= 1'b1;
                    else if (hi >= ad) ov <= 1'b1;
                    pr  <= hi;
                    sr  <= lo;
                    cnt <= CW'(N);
                end
                RUN: begin
                    pr  <= ge ? trial : rem[N-1:0];
                    sr  <= {sr[N-2:0], ge};
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    ov <= fix_ov;
                    q  <= fix_ov ? '0 : (neg ? -sr : sr);
                    w  <= fix_ov ? '0 : (sx ? -pr : pr);
                end
                default: ;
            endcase
        end
    end
endmodule
